// File: rtl/ts_pkg.sv
// Shared constants, stamp type and latency-compensation helper for the
// timestamp capture unit.
package ts_pkg;

  localparam int COUNT_W     = 32;
  localparam int EPOCH_W_DEF = 16;

  typedef struct packed {
    logic [EPOCH_W_DEF-1:0] epoch;
    logic [COUNT_W-1:0]     count;
  } ts_t;

  // Cycles between evt_in first being sampled and the push-request cycle.
  function automatic int lat_offset(input int sync_stages);
    return sync_stages + 1;
  endfunction

endpackage

// File: rtl/ts_fifo.sv
// Synchronous first-word-fall-through FIFO; dout shows the head entry and
// keeps the last shown value while empty.
module ts_fifo
  import ts_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int WIDTH = 48
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   flush,
  input  logic                   push,
  input  logic                   pop,
  input  logic [WIDTH-1:0]       din,
  output logic [WIDTH-1:0]       dout,
  output logic                   empty,
  output logic                   full,
  output logic [$clog2(DEPTH):0] level
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic [WIDTH-1:0] hold_q;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count == '0);
  assign full    = (count == (AW+1)'(DEPTH));
  assign do_pop  = pop && !empty;
  // A pop in the same cycle frees the slot the push is about to use.
  assign do_push = push && (!full || do_pop);
  assign level   = count;
  assign dout    = empty ? hold_q : mem[rd_ptr];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !flush) mem[wr_ptr] <= din;
  end

  // Tracks the currently displayed head so dout holds steady once empty.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hold_q <= '0;
    end else if (!empty) begin
      hold_q <= mem[rd_ptr];
    end
  end

endmodule

// File: rtl/ts_capture.sv
// Timestamp capture: 48-bit time base from timer + epoch, synchronised event
// edges stamped into a FWFT FIFO. Option macro: TS_CAPTURE_LAT_COMP_EN.
module ts_capture
  import ts_pkg::*;
#(
  parameter int DEPTH       = 8,
  parameter int EPOCH_W     = EPOCH_W_DEF,
  parameter int SYNC_STAGES = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       tmr_clr,
  input  logic                       tmr_ena,
  input  logic [COUNT_W-1:0]         tmr_count,
  input  logic                       evt_in,
  input  logic                       rd_en,
  output logic [COUNT_W+EPOCH_W-1:0] ts_data,
  output logic                       ts_valid,
  output logic [$clog2(DEPTH):0]     fifo_level,
  output logic                       overflow,
  output logic [15:0]                drop_cnt
);

  localparam int TS_W = COUNT_W + EPOCH_W;

  logic [EPOCH_W-1:0]     epoch_q;
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   hist_q;
  logic                   push_q;
  logic [TS_W-1:0]        raw_stamp;
  logic [TS_W-1:0]        stamp;
  logic                   fifo_push;
  logic                   fifo_empty;
  logic                   fifo_full;
  logic                   drop;

  // Epoch advances on exactly the condition that wraps the external timer.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      epoch_q <= '0;
    end else if (tmr_clr) begin
      epoch_q <= '0;
    end else if (tmr_ena && (tmr_count == '1)) begin
      epoch_q <= epoch_q + 1'b1;
    end
  end

  // History always follows the last stage, so a level held across a clear
  // never looks like a fresh edge; a clear also kills an edge in flight.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync_q <= '0;
      hist_q <= 1'b0;
      push_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], evt_in};
      hist_q <= sync_q[SYNC_STAGES-1];
      push_q <= !tmr_clr && sync_q[SYNC_STAGES-1] && !hist_q;
    end
  end

  assign raw_stamp = {epoch_q, tmr_count};

`ifdef TS_CAPTURE_LAT_COMP_EN
  localparam logic [TS_W-1:0] LAT_OFFSET = TS_W'(lat_offset(SYNC_STAGES));
  assign stamp = raw_stamp - LAT_OFFSET;
`else
  assign stamp = raw_stamp;
`endif

  assign fifo_push = push_q && !tmr_clr;
  assign drop      = fifo_push && fifo_full && !rd_en;
  assign ts_valid  = !fifo_empty;

  ts_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (TS_W)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .flush (tmr_clr),
    .push  (fifo_push),
    .pop   (rd_en),
    .din   (stamp),
    .dout  (ts_data),
    .empty (fifo_empty),
    .full  (fifo_full),
    .level (fifo_level)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      overflow <= 1'b0;
      drop_cnt <= '0;
    end else if (tmr_clr) begin
      overflow <= 1'b0;
      drop_cnt <= '0;
    end else if (drop) begin
      overflow <= 1'b1;
      if (drop_cnt != 16'hFFFF) drop_cnt <= drop_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_ts_capture.sv
// Directed self-checking bench for ts_capture (DEPTH=8, EPOCH_W=16,
// SYNC_STAGES=2); expectations follow TS_CAPTURE_LAT_COMP_EN when defined.
module tb_ts_capture;
  import ts_pkg::*;

`ifdef TS_CAPTURE_LAT_COMP_EN
  localparam logic [47:0] LAT = 48'd3;
`else
  localparam logic [47:0] LAT = 48'd0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        tmr_clr = 1'b0;
  logic        tmr_ena = 1'b0;
  logic [31:0] tmr_count = 32'd0;
  logic        evt_in = 1'b0;
  logic        rd_en = 1'b0;
  logic [47:0] ts_data;
  logic        ts_valid;
  logic [3:0]  fifo_level;
  logic        overflow;
  logic [15:0] drop_cnt;

  logic [15:0] epoch_m = 16'd0;
  int          tests = 0;
  int          fails = 0;
  ts_t         stamps [10];
  ts_t         s_new;

  ts_capture #(.DEPTH(8), .EPOCH_W(16), .SYNC_STAGES(2)) dut (
    .clk        (clk),
    .rst        (rst),
    .tmr_clr    (tmr_clr),
    .tmr_ena    (tmr_ena),
    .tmr_count  (tmr_count),
    .evt_in     (evt_in),
    .rd_en      (rd_en),
    .ts_data    (ts_data),
    .ts_valid   (ts_valid),
    .fifo_level (fifo_level),
    .overflow   (overflow),
    .drop_cnt   (drop_cnt)
  );

  always #5 clk = ~clk;

  // One clock; the bench plays the role of the 32-bit timer and epoch model.
  task automatic step();
    @(posedge clk);
    #1;
    if (tmr_clr) begin
      tmr_count = 32'd0;
      epoch_m   = 16'd0;
    end else if (tmr_ena) begin
      if (tmr_count == 32'hFFFFFFFF) epoch_m = epoch_m + 16'd1;
      tmr_count = tmr_count + 32'd1;
    end
  endtask

  task automatic clear_timer();
    tmr_clr = 1'b1;
    step();
    tmr_clr = 1'b0;
  endtask

  task automatic pulse(input logic pop_at_push, output ts_t s);
    evt_in = 1'b1;
    step();
    evt_in = 1'b0;
    step();
    step();
    s = {epoch_m, tmr_count} - LAT;
    rd_en = pop_at_push;
    step();
    rd_en = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    step();
    step();
    tests++;
    if (ts_valid !== 1'b0 || fifo_level !== 4'd0) begin
      fails++;
      $display("[TB] FAIL reset_fifo: valid=%b level=%0d required valid=0 level=0", ts_valid, fifo_level);
    end
    tests++;
    if (overflow !== 1'b0 || drop_cnt !== 16'd0 || ts_data !== 48'd0) begin
      fails++;
      $display("[TB] FAIL reset_status: ovf=%b drop=%0d data=%h required 0/0/0", overflow, drop_cnt, ts_data);
    end
    rst = 1'b1;
    step();
  endtask

  task automatic test_single();
    tmr_ena   = 1'b1;
    tmr_count = 32'd100;
    evt_in    = 1'b1;
    step();
    evt_in = 1'b0;
    step();
    step();
    tests++;
    if (ts_valid !== 1'b0) begin
      fails++;
      $display("[TB] FAIL single_latency: valid=%b required 0 before push", ts_valid);
    end
    step();
    tests++;
    if (ts_valid !== 1'b1 || fifo_level !== 4'd1) begin
      fails++;
      $display("[TB] FAIL single_valid: valid=%b level=%0d required 1/1", ts_valid, fifo_level);
    end
    tests++;
    if (ts_data !== 48'h0000_00000067 - LAT) begin
      fails++;
      $display("[TB] FAIL single_stamp: got %h required %h", ts_data, 48'h0000_00000067 - LAT);
    end
    rd_en = 1'b1;
    step();
    rd_en = 1'b0;
    tests++;
    if (ts_valid !== 1'b0 || ts_data !== 48'h0000_00000067 - LAT) begin
      fails++;
      $display("[TB] FAIL single_hold: valid=%b data=%h required 0/%h", ts_valid, ts_data, 48'h0000_00000067 - LAT);
    end
    rd_en = 1'b1;
    step();
    rd_en = 1'b0;
    tests++;
    if (fifo_level !== 4'd0) begin
      fails++;
      $display("[TB] FAIL underflow: level=%0d required 0", fifo_level);
    end
  endtask

  task automatic test_epoch_roll();
    clear_timer();
    tmr_count = 32'hFFFFFFFC;
    pulse(1'b0, s_new);
    tests++;
    if (ts_data !== 48'h0000_FFFFFFFF - LAT) begin
      fails++;
      $display("[TB] FAIL epoch_last: got %h required %h", ts_data, 48'h0000_FFFFFFFF - LAT);
    end
    rd_en = 1'b1;
    step();
    rd_en = 1'b0;
    clear_timer();
    tmr_count = 32'hFFFFFFFD;
    pulse(1'b0, s_new);
    tests++;
    if (ts_data !== 48'h0001_00000000 - LAT) begin
      fails++;
      $display("[TB] FAIL epoch_first: got %h required %h", ts_data, 48'h0001_00000000 - LAT);
    end
    rd_en = 1'b1;
    step();
    rd_en = 1'b0;
  endtask

  task automatic test_epoch_borrow();
    logic [47:0] want;
`ifdef TS_CAPTURE_LAT_COMP_EN
    want = 48'h0000_FFFFFFFE;
`else
    want = 48'h0001_00000001;
`endif
    clear_timer();
    tmr_count = 32'hFFFFFFFE;
    pulse(1'b0, s_new);
    tests++;
    if (ts_data !== want) begin
      fails++;
      $display("[TB] FAIL epoch_borrow: got %h required %h", ts_data, want);
    end
    rd_en = 1'b1;
    step();
    rd_en = 1'b0;
  endtask

  task automatic test_clear();
    for (int i = 0; i < 3; i++) pulse(1'b0, s_new);
    evt_in = 1'b1;
    for (int i = 0; i < 5; i++) step();
    tests++;
    if (fifo_level !== 4'd4) begin
      fails++;
      $display("[TB] FAIL clear_prefill: level=%0d required 4", fifo_level);
    end
    clear_timer();
    tests++;
    if (fifo_level !== 4'd0 || ts_valid !== 1'b0 || overflow !== 1'b0 || drop_cnt !== 16'd0) begin
      fails++;
      $display("[TB] FAIL clear_flush: level=%0d valid=%b ovf=%b drop=%0d required 0/0/0/0",
               fifo_level, ts_valid, overflow, drop_cnt);
    end
    for (int i = 0; i < 5; i++) step();
    tests++;
    if (fifo_level !== 4'd0) begin
      fails++;
      $display("[TB] FAIL clear_held_high: level=%0d required 0", fifo_level);
    end
    evt_in = 1'b0;
    for (int i = 0; i < 3; i++) step();
    pulse(1'b0, s_new);
    tests++;
    if (fifo_level !== 4'd1 || ts_data !== s_new || ts_data[47:32] !== 16'd0) begin
      fails++;
      $display("[TB] FAIL clear_rearm: level=%0d data=%h required 1/%h", fifo_level, ts_data, s_new);
    end
    rd_en = 1'b1;
    step();
    rd_en = 1'b0;
  endtask

  task automatic test_overflow();
    clear_timer();
    for (int i = 0; i < 10; i++) pulse(1'b0, stamps[i]);
    tests++;
    if (fifo_level !== 4'd8 || overflow !== 1'b1 || drop_cnt !== 16'd2) begin
      fails++;
      $display("[TB] FAIL overflow_status: level=%0d ovf=%b drop=%0d required 8/1/2",
               fifo_level, overflow, drop_cnt);
    end
    for (int i = 0; i < 8; i++) begin
      tests++;
      if (ts_valid !== 1'b1 || ts_data !== stamps[i]) begin
        fails++;
        $display("[TB] FAIL overflow_read%0d: valid=%b data=%h required 1/%h", i, ts_valid, ts_data, stamps[i]);
      end
      rd_en = 1'b1;
      step();
      rd_en = 1'b0;
    end
    tests++;
    if (ts_valid !== 1'b0 || fifo_level !== 4'd0) begin
      fails++;
      $display("[TB] FAIL overflow_drained: valid=%b level=%0d required 0/0", ts_valid, fifo_level);
    end
  endtask

  task automatic test_full_push_pop();
    for (int i = 0; i < 8; i++) pulse(1'b0, stamps[i]);
    pulse(1'b1, s_new);
    tests++;
    if (fifo_level !== 4'd8 || drop_cnt !== 16'd2 || overflow !== 1'b1) begin
      fails++;
      $display("[TB] FAIL full_pushpop_status: level=%0d drop=%0d ovf=%b required 8/2/1",
               fifo_level, drop_cnt, overflow);
    end
    stamps[8] = s_new;
    for (int i = 1; i < 9; i++) begin
      tests++;
      if (ts_data !== stamps[i]) begin
        fails++;
        $display("[TB] FAIL full_pushpop_order%0d: got %h required %h", i, ts_data, stamps[i]);
      end
      rd_en = 1'b1;
      step();
      rd_en = 1'b0;
    end
    tests++;
    if (ts_valid !== 1'b0) begin
      fails++;
      $display("[TB] FAIL full_pushpop_drained: valid=%b required 0", ts_valid);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_epoch_roll();
    test_epoch_borrow();
    test_clear();
    test_overflow();
    test_full_push_pop();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/ts_capture.md
Name: ts_capture

Overview:
- Timestamp capture unit that consumes the 32-bit free-running timer count and its clear/enable controls.
- Extends the timer to a 48-bit time base using a 16-bit epoch counter.
- Stamps rising edges of an asynchronous external event into a FWFT FIFO.
- Downstream logic (acquisition framer / host readout) drains timestamps through a valid/read handshake.

Parameters:
- DEPTH, 8, FIFO depth in entries; power of 2, minimum 2.
- EPOCH_W, 16, epoch counter width; stamp width = 32 + EPOCH_W.
- SYNC_STAGES, 2, synchroniser flops on evt_in; minimum 2.

Ports:
- clk  in  1  working clock, same domain as the timer.
- rst  in  1  reset, asynchronous, active-low.
- tmr_clr  in  1  timer synchronous clear, same signal that drives the timer.
- tmr_ena  in  1  timer count enable, same signal that drives the timer.
- tmr_count  in  32  timer count output.
- evt_in  in  1  asynchronous event input.
- rd_en  in  1  pop request; honoured only while ts_valid=1.
- ts_data  out  32+EPOCH_W  head-of-FIFO stamp {epoch, count}.
- ts_valid  out  1  FIFO not empty.
- fifo_level  out  clog2(DEPTH)+1  entries stored.
- overflow  out  1  sticky: at least one event dropped.
- drop_cnt  out  16  dropped-event count, saturates at 16'hFFFF.

Behaviour:
- Reset values (rst=0): epoch=0, sync chain=0, edge-detect history=0, FIFO empty, ts_valid=0, ts_data=0, fifo_level=0, overflow=0, drop_cnt=0.
- Epoch update:
  - tmr_clr=1: epoch <= 0.
  - Else, tmr_ena=1 and tmr_count==32'hFFFFFFFF: epoch <= epoch+1, wrapping modulo 2^EPOCH_W. This is the same condition on which the timer wraps.
- Synchronisation and edge detection:
  - evt_in passes through SYNC_STAGES flops.
  - A rising edge is detected when the last stage = 1 and the history flop = 0. The history flop holds the previous value of the last stage.
  - Edge detection produces a single-cycle push request.
- Stamp value: {epoch, tmr_count} as present in the push-request cycle, i.e. the pre-update values.
  - A push coinciding with an epoch increment stores the old epoch with count FFFFFFFF, so stamps stay consistent.
- Latency:
  - Pin-to-push-request: SYNC_STAGES+1 cycles.
  - The entry is visible on ts_valid/ts_data on the cycle after the push.
- FIFO: first-word-fall-through.
  - ts_data always shows the head entry; it holds its last value when empty.
  - rd_en with ts_valid=1 pops at the clock edge.
  - rd_en with ts_valid=0 is ignored; no underflow.
- Full, push without pop: the new event is dropped.
  - overflow <= 1, sticky.
  - drop_cnt increments, saturating at FFFF.
- Full, push with simultaneous pop: both are performed; nothing dropped; level unchanged.
- Any level, push with simultaneous pop: level unchanged; stored order preserved.
- tmr_clr=1:
  - FIFO flushed; overflow and drop_cnt cleared.
  - A push request in the same cycle is discarded.
  - The sync chain keeps running, but the history flop is loaded with the last sync stage so that a level held high across the clear produces no edge.
- Pointer widths: clog2(DEPTH); pointers wrap naturally.

Optional Feature:
- Macro: TS_CAPTURE_LAT_COMP_EN.
- Defined: the stored stamp is {epoch, tmr_count} minus (SYNC_STAGES+1), computed modulo 2^(32+EPOCH_W). The stamp then refers to the cycle evt_in was first sampled. Borrow across the epoch boundary is handled, e.g. {0001, 00000001} with SYNC_STAGES=2 becomes {0000, FFFFFFFE}.
- Undefined: the raw stamp is stored; no subtractor is present.

Decomposition:
- Package ts_pkg holds:
  - COUNT_W=32 and the default EPOCH_W.
  - typedef ts_t, the packed {epoch, count} stamp.
  - The LAT_COMP offset constant function.
- Sub-module ts_fifo: synchronous FWFT FIFO with DEPTH and width parameters. Ports: push, pop, din, dout, empty, full, level. ts_capture instantiates it once; overflow/drop logic stays in the top.

Test Plan:
- Reset then idle: ts_valid=0, fifo_level=0, overflow=0, drop_cnt=0. Single evt_in pulse while tmr_count=100, tmr_ena=1 → one entry; ts_data={0000, 100+SYNC_STAGES+1}, raw mode.
- Epoch roll: tmr_count forced from FFFFFFFD with tmr_ena=1 → epoch becomes 0001 when count=0. An event whose push lands on the FFFFFFFF cycle stamps {0000, FFFFFFFF}; the next cycle stamps {0001, 00000000}.
- Overflow with DEPTH=8: 10 events, no reads → fifo_level=8, overflow=1, drop_cnt=2. Read 8 → stamps in order; ts_valid falls after the 8th pop.
- Full with simultaneous push+pop: level stays 8, drop_cnt unchanged, popped entry is the oldest.
- tmr_clr with 3 entries queued and evt_in held high → fifo_level=0, epoch=0, overflow=0, drop_cnt=0; no new stamp until evt_in falls and rises again.
- TS_CAPTURE_LAT_COMP_EN defined, event pushed at {0001, 00000001} with SYNC_STAGES=2 → ts_data={0000, FFFFFFFE}.
